// File: rtl/uart_pkg.sv
// Shared constants and types for the UART ping test path: message bytes,
// reply-state encoding and the saturating counter helper.
package uart_pkg;

    localparam int msg_len = 6;
    localparam int cnt_w   = 16;

    localparam logic [7:0] req_bytes [msg_len] = '{8'h70, 8'h69, 8'h6E, 8'h67, 8'h0D, 8'h0A};
    localparam logic [7:0] rsp_bytes [msg_len] = '{8'h70, 8'h6F, 8'h6E, 8'h67, 8'h0D, 8'h0A};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } reply_state_t;

    function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] value);
        return (value == {cnt_w{1'b1}}) ? value : value + cnt_w'(1);
    endfunction

endpackage

// File: rtl/ping_matcher.sv
// Scans accepted bytes for "ping\r\n"; emits single-cycle match and error
// pulses that are valid in the cycle of the deciding byte or the gap timeout.
module ping_matcher
    import uart_pkg::*;
#(
    parameter int gap_max = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       accept,
    output logic       match,
    output logic       error
);

    logic [2:0]  idx;
    logic [15:0] gap;
    logic        hit;
    logic        at_last;
    logic        timeout;

    assign hit     = (data == req_bytes[idx]);
    assign at_last = (idx == 3'(msg_len - 1));
    // Gap counts idle clocks since the last accepted byte; it expires on the
    // gap_max-th idle clock.
    assign timeout = !accept && (idx != 3'd0) && (gap == 16'(gap_max - 1));
    assign match   = accept && hit && at_last;
    assign error   = (accept && !hit && (idx != 3'd0)) || timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx <= 3'd0;
            gap <= 16'd0;
        end else if (accept) begin
            gap <= 16'd0;
            if (hit) begin
                idx <= at_last ? 3'd0 : idx + 3'd1;
            end else begin
                idx <= (data == req_bytes[0]) ? 3'd1 : 3'd0;
            end
        end else if (idx != 3'd0) begin
            if (timeout) begin
                idx <= 3'd0;
                gap <= 16'd0;
            end else begin
                gap <= gap + 16'd1;
            end
        end else begin
            gap <= 16'd0;
        end
    end

endmodule

// File: rtl/ping_responder.sv
// Answers each "ping\r\n" on the receive stream with "pong\r\n" on the
// transmit stream, with one queued reply and saturating event counters.
//
// Handshake: a byte moves on a port in any cycle where its valid and ready are
// both high at the rising clock edge; the input side is always ready out of reset.
module ping_responder
    import uart_pkg::*;
#(
    parameter int gap_max = 255
) (
    input  logic        _clock,
    input  logic        _reset,
    input  logic [7:0]  _in,
    input  logic        _in_valid,
    output logic        _in_ready,
    output logic [7:0]  _out,
    output logic        _out_valid,
    input  logic        _out_ready,
    output logic [15:0] _ping_count,
    output logic [15:0] _error_count,
    output logic [15:0] _drop_count
);

    reply_state_t state;
    logic [2:0]   cursor;
    logic         pending;
    logic         accept;
    logic         match;
    logic         error;
    logic         handshake;
    logic         final_hs;

    assign _in_ready = _reset;
    assign accept    = _in_valid && _in_ready;
    assign handshake = _out_valid && _out_ready;
    assign final_hs  = handshake && (cursor == 3'(msg_len - 1));

    ping_matcher #(
        .gap_max (gap_max)
    ) u_matcher (
        .clock  (_clock),
        .reset  (_reset),
        .data   (_in),
        .accept (accept),
        .match  (match),
        .error  (error)
    );

    // _out/_out_valid are loaded with the byte for the next cursor so they
    // come straight from flops.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state       <= IDLE;
            cursor      <= 3'd0;
            pending     <= 1'b0;
            _out_valid  <= 1'b0;
            _out        <= 8'h00;
            _drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state      <= SEND;
                        cursor     <= 3'd0;
                        _out_valid <= 1'b1;
                        _out       <= rsp_bytes[0];
                    end
                end
                SEND: begin
                    if (final_hs) begin
                        if (match || pending) begin
                            cursor <= 3'd0;
                            _out   <= rsp_bytes[0];
                            // A fresh match restarts the reply and leaves any queued one queued.
                            if (!match) begin
                                pending <= 1'b0;
                            end
                        end else begin
                            state      <= IDLE;
                            cursor     <= 3'd0;
                            _out_valid <= 1'b0;
                            _out       <= 8'h00;
                        end
                    end else begin
                        if (handshake) begin
                            cursor <= cursor + 3'd1;
                            _out   <= rsp_bytes[cursor + 3'd1];
                        end
                        if (match) begin
                            if (pending) begin
                                _drop_count <= sat_inc(_drop_count);
                            end else begin
                                pending <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cursor     <= 3'd0;
                    pending    <= 1'b0;
                    _out_valid <= 1'b0;
                    _out       <= 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            _ping_count  <= '0;
            _error_count <= '0;
        end else begin
            if (match) begin
                _ping_count <= sat_inc(_ping_count);
            end
            if (error) begin
                _error_count <= sat_inc(_error_count);
            end
        end
    end

endmodule
